// File: rtl/mdu_riscv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, start/busy/valid handshake, one operation in flight.
module mdu_riscv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      LAST_IT  = 6'(XLEN - 1);

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] hi_q, hi_d;   // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;   // multiplier / dividend shifting into quotient
  logic [XLEN-1:0] m_q, m_d;     // multiplicand / divisor magnitude
  logic            neg_q, neg_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  // Operand conditioning at acceptance.
  logic            a_signed, b_signed, a_sgn, b_sgn, is_div;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_div   = op_i[2];
  assign a_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                    (op_i == OP_DIV) || (op_i == OP_REM);
  assign b_signed = (op_i == OP_MUL) || (op_i == OP_MULH) ||
                    (op_i == OP_DIV) || (op_i == OP_REM);
  assign a_sgn    = a_signed && a_i[XLEN-1];
  assign b_sgn    = b_signed && b_i[XLEN-1];
  assign a_mag    = a_sgn ? -a_i : a_i;
  assign b_mag    = b_sgn ? -b_i : b_i;

  // One multiply step: conditional add of the multiplicand, then shift right.
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi, mul_lo;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign mul_hi  = mul_sum[XLEN:1];
  assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

  // One restoring-divide step; div_part carries the guard bit for the compare.
  logic [XLEN:0]   div_part;
  logic [XLEN-1:0] div_diff, div_rem, div_lo;
  logic            div_ok;

  assign div_part = {hi_q, lo_q[XLEN-1]};
  assign div_ok   = (div_part >= {1'b0, m_q});
  assign div_diff = div_part[XLEN-1:0] - m_q;
  assign div_rem  = div_ok ? div_diff : div_part[XLEN-1:0];
  assign div_lo   = {lo_q[XLEN-2:0], div_ok};

  // Sign correction on the values produced by the final iteration.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, final_res;

  assign prod_s = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
  assign quot_s = neg_q ? -div_lo : div_lo;
  assign rem_s  = neg_rem_q ? -div_rem : div_rem;

  always_comb begin
    final_res = prod_s[XLEN-1:0];
    unique case (op_q)
      OP_MUL:                        final_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = dz_q ? ALL_ONES : (ovf_q ? INT_MIN : quot_s);
      // A zero divisor leaves the dividend as remainder, so rem_s is already a_i.
      OP_REM, OP_REMU:               final_res = ovf_q ? '0 : rem_s;
      default:                       final_res = prod_s[XLEN-1:0];
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          op_d      = op_i;
          rd_d      = rd_addr_i;
          hi_d      = '0;
          lo_d      = is_div ? a_mag : b_mag;
          m_d       = is_div ? b_mag : a_mag;
          neg_d     = a_sgn ^ b_sgn;
          neg_rem_d = a_sgn;
          dz_d      = (b_i == '0);
          ovf_d     = is_div && !op_i[0] && (a_i == INT_MIN) && (b_i == ALL_ONES);
        end
      end
      S_CALC: begin
        hi_d  = op_q[2] ? div_rem : mul_hi;
        lo_d  = op_q[2] ? div_lo  : mul_lo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_IT) begin
          state_d  = S_DONE;
          result_d = final_res;
          rd_out_d = rd_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; all registers are reset so a mid-operation reset
  // leaves nothing stale behind.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      m_q       <= m_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign valid_o   = (state_q == S_DONE);
  assign result_o  = result_q;
  assign rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_mdu_riscv.sv
// Self-checking bench for mdu_riscv: directed latency/handshake/reset cases plus
// a random regression against a reference model through a result scoreboard.
module tb_mdu_riscv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  rd = '0;
  logic        busy, valid;
  logic [31:0] res;
  logic [4:0]  rdo;

  int total = 0;
  int bad = 0;
  int n_valid = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  mdu_riscv #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .rd_addr_i(rd), .busy_o(busy), .valid_o(valid), .result_o(res), .rd_addr_o(rdo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xs, ys, xu, yu, p;
    int sx, sy;
    logic ovf;
    xs = {{32{x[31]}}, x};
    ys = {{32{y[31]}}, y};
    xu = {32'b0, x};
    yu = {32'b0, y};
    sx = x;
    sy = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    model = '0;
    case (f)
      3'd0: begin p = xs * ys; model = p[31:0]; end
      3'd1: begin p = xs * ys; model = p[63:32]; end
      3'd2: begin p = xs * yu; model = p[63:32]; end
      3'd3: begin p = xu * yu; model = p[63:32]; end
      3'd4: begin
        if (y == 0) model = 32'hFFFF_FFFF;
        else if (ovf) model = 32'h8000_0000;
        else model = sx / sy;
      end
      3'd5: begin
        if (y == 0) model = 32'hFFFF_FFFF;
        else model = x / y;
      end
      3'd6: begin
        if (y == 0) model = x;
        else if (ovf) model = '0;
        else model = sx % sy;
      end
      default: begin
        if (y == 0) model = x;
        else model = x % y;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'h0;
      1: pick = 32'h1;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h8000_0000;
      4: pick = 32'h2;
      default: pick = $urandom();
    endcase
  endfunction

  // Scoreboard monitor: every valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", res, mon_e.res);
        check("rd_addr", rdo, mon_e.rd);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge E0.
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_before_issue", busy, 0);
    op = f; a = x; b = y; rd = r; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input logic [31:0] exp);
    int nv;
    sb_q.push_back('{rd: r, res: exp});
    nv = n_valid;
    issue(f, x, y, r);
    repeat (31) @(posedge clk);
    @(negedge clk);
    check("no_valid_before_E32", valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("valid_after_E32", valid, 1);
    check("busy_in_done", busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("idle_after_E33", {busy, valid}, 2'b00);
    check("single_valid_pulse", n_valid - nv, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    logic [2:0]  f;
    logic [31:0] x, y;

    #12;
    check("reset_outputs", {busy, valid, res, rdo}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3, 32'hFFFF_FFFF);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd7, 32'hFFFF_FFFF);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2,         5'd8, 32'h7FFF_FFFC);
    run_op(3'd5, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd5,         32'd0,         5'd11, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0);
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0,         5'd14, 32'hFFFF_FFFB);

    // Handshake: start pulses while busy (at E10) and in DONE must be ignored.
    sb_q.push_back('{rd: 5'd5, res: 32'h0001_2340});
    nv = n_valid;
    issue(3'd0, 32'h0000_1234, 32'h10, 5'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    op = 3'd4; a = 32'd100; b = 32'd7; rd = 5'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(posedge clk);
    @(negedge clk);
    check("hs_valid_E32", valid, 1);
    check("hs_rd", rdo, 5);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hs_no_accept_in_done", busy, 0);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("hs_still_idle", busy, 0);
    repeat (40) @(negedge clk);
    check("hs_one_retire", n_valid - nv, 1);

    // Asynchronous reset between edges at E15 of a DIV.
    issue(3'd4, 32'd1000, 32'd3, 5'd17);
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", {busy, valid, res, rdo}, '0);
    @(negedge clk);
    rst = 1'b0;
    nv = n_valid;
    repeat (40) @(negedge clk);
    check("rst_no_valid", n_valid - nv, 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd20, 32'd12);

    // Random regression through the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      f = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      sb_q.push_back('{rd: 5'(i), res: model(f, x, y)});
      issue(f, x, y, 5'(i));
    end
    repeat (40) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
